gravador_sequencia: RTL and testbench
=====================================

GRAVADOR_SEQUENCIA -- requirements
Module: gravador_sequencia

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of stored note events (power of 2, >=4).
REQ-002 SHALL have parameter NOTA_W, default 4, note-code width.
REQ-003 SHALL have parameter DUR_W, default 4, duration width in metronome ticks.
REQ-004 SHALL have parameter ERRO_W, default 3, error-counter width.
REQ-005 SHALL have ports:
  - clock  in  1  single clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - tick  in  1  one-cycle metronome pulse.
  - modo  in  2  00 none, 01 grava, 10 toca, 11 pratica; sampled only on inicia.
  - inicia  in  1  one-cycle start pulse.
  - para  in  1  one-cycle abort pulse.
  - nota  in  NOTA_W  encoded key.
  - nota_valida  in  1  key-held level.
  - nota_out  out  NOTA_W  note being played or expected.
  - nota_out_valida  out  1  nota_out meaningful.
  - endereco  out  log2(DEPTH)  current event index.
  - comprimento  out  log2(DEPTH)+1  events recorded.
  - erros  out  ERRO_W  practice error count.
  - acerto  out  1  one-cycle correct-note pulse.
  - erro  out  1  one-cycle wrong-note pulse.
  - ocupado  out  1  high in GRAVA, TOCA or PRATICA.
  - fim  out  1  high in FIM.

Function
REQ-006 SHALL implement states OCIOSO, GRAVA, TOCA, PRATICA, FIM.
REQ-007 OCIOSO + inicia SHALL go to GRAVA/TOCA/PRATICA per modo; modo=00 SHALL stay OCIOSO; TOCA/PRATICA with comprimento=0 SHALL go directly to FIM.
REQ-008 Entering GRAVA SHALL clear comprimento and endereco; entering TOCA/PRATICA SHALL clear endereco, erros and the duration counter.
REQ-009 para SHALL move any active state to FIM next cycle, without writing a partial event.
REQ-010 FIM SHALL return to OCIOSO on inicia or after exactly one cycle without inicia; an inicia arriving in FIM SHALL be treated as arriving in OCIOSO.
REQ-011 GRAVA: nota_valida rising edge (internal edge detector) SHALL latch nota and clear the duration counter; each tick while held SHALL increment it, saturating at 2^DUR_W-1.
REQ-012 GRAVA: nota_valida falling edge SHALL write {latched nota, duration} at endereco, then increment endereco and comprimento in the same cycle.
REQ-013 GRAVA: write at endereco=DEPTH-1 SHALL set comprimento=DEPTH and transition to FIM.
REQ-014 TOCA: SHALL present stored note on nota_out with nota_out_valida=1; duration counter counts ticks; when count+1 equals stored duration on a tick, endereco SHALL advance; stored duration 0 SHALL be treated as 1.
REQ-015 TOCA: advancing past comprimento-1 SHALL go to FIM.
REQ-016 PRATICA: nota_out SHALL show expected note; on nota_valida rising edge, equal note SHALL pulse acerto and advance endereco; unequal SHALL pulse erro, increment erros (saturating at 2^ERRO_W-1), and hold endereco.
REQ-017 PRATICA: correct note at comprimento-1 SHALL go to FIM.
REQ-018 Memory read data SHALL be valid one cycle after endereco changes; nota_out_valida SHALL be 0 in that cycle.
REQ-019 Edges and ticks arriving simultaneously with para SHALL be ignored.
REQ-020 erros SHALL hold its value through FIM and OCIOSO until next TOCA/PRATICA start.

Reset
REQ-021 reset SHALL force OCIOSO, endereco=0, comprimento=0, erros=0, duration counter=0, nota_out=0, all pulses/flags 0, within one clock edge.
REQ-022 Memory contents SHALL NOT be cleared by reset; comprimento=0 makes them unreachable.
REQ-023 reset mid-GRAVA SHALL discard the in-progress event.

Configuration
REQ-024 Macro GRAVADOR_LOOP_EN: when defined, TOCA past comprimento-1 SHALL wrap endereco to 0 and continue until para; when undefined, REQ-015 applies.

Verification
REQ-025 Record: inicia modo=01, press note 5 for 3 ticks, note 9 for 2 ticks -> comprimento=2, mem[0]={5,3}, mem[1]={9,2}.
REQ-026 Play: after REQ-025, inicia modo=10 -> nota_out=5 for 3 ticks, 9 for 2 ticks, fim=1, ocupado=0 (loop build: returns to 5).
REQ-027 Practice: after REQ-025, inicia modo=11, press 7 then 5 then 9 -> erro once, acerto twice, erros=1, FIM.
REQ-028 Full: DEPTH=4, record 4 notes -> FIM after 4th release, comprimento=4; 5th press ignored.
REQ-029 Abort/reset: para while key held in GRAVA -> comprimento unchanged; reset mid-TOCA -> OCIOSO, all outputs 0 next cycle.
REQ-030 Saturation: hold note 20 ticks with DUR_W=4 -> stored duration 15; 9 wrong notes with ERRO_W=3 -> erros=7.

Source files
------------

// File: rtl/gravador_sequencia.sv
// Note-sequence recorder/player/trainer: records key presses with tick durations, replays them, or checks a performer against them.
// Optional build macro GRAVADOR_LOOP_EN makes playback wrap to the first event instead of finishing.
module gravador_sequencia #(
    parameter int DEPTH  = 256,
    parameter int NOTA_W = 4,
    parameter int DUR_W  = 4,
    parameter int ERRO_W = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [1:0]                 modo,
    input  logic                       inicia,
    input  logic                       para,
    input  logic [NOTA_W-1:0]          nota,
    input  logic                       nota_valida,
    output logic [NOTA_W-1:0]          nota_out,
    output logic                       nota_out_valida,
    output logic [$clog2(DEPTH)-1:0]   endereco,
    output logic [$clog2(DEPTH):0]     comprimento,
    output logic [ERRO_W-1:0]          erros,
    output logic                       acerto,
    output logic                       erro,
    output logic                       ocupado,
    output logic                       fim
);
    localparam int AW = $clog2(DEPTH);
    localparam int MW = NOTA_W + DUR_W;

    typedef enum logic [2:0] {OCIOSO, GRAVA, TOCA, PRATICA, FIM} estado_t;

    function automatic logic [DUR_W-1:0] sat_dur(input logic [DUR_W-1:0] v);
        return (&v) ? v : v + DUR_W'(1);
    endfunction

    function automatic logic [ERRO_W-1:0] sat_erro(input logic [ERRO_W-1:0] v);
        return (&v) ? v : v + ERRO_W'(1);
    endfunction

    estado_t             estado_q, estado_d;
    logic [AW-1:0]       end_q, end_d;
    logic [AW:0]         comp_q, comp_d;
    logic [ERRO_W-1:0]   erros_q, erros_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                held_q, held_d;
    logic                nv_q;
    logic                acerto_q, acerto_d;
    logic                erro_q, erro_d;
    logic                rd_vld_q, rd_vld_d;
    logic [NOTA_W-1:0]   nota_lat_q, nota_lat_d;
    logic [MW-1:0]       rd_data_q;
    logic [MW-1:0]       mem [DEPTH];
    logic                we;

    logic                subida, descida, ultimo;
    logic [NOTA_W-1:0]   rd_nota;
    logic [DUR_W:0]      dur_prox, dur_ef;

    assign subida   = nota_valida & ~nv_q;
    assign descida  = ~nota_valida & nv_q;
    assign rd_nota  = rd_data_q[MW-1:DUR_W];
    assign dur_prox = {1'b0, dur_q} + (DUR_W+1)'(1);
    // A stored duration of zero plays as a single tick.
    assign dur_ef   = (rd_data_q[DUR_W-1:0] == '0) ? (DUR_W+1)'(1)
                                                   : {1'b0, rd_data_q[DUR_W-1:0]};
    assign ultimo   = (({1'b0, end_q}) + (AW+1)'(1)) == comp_q;

    always_comb begin
        estado_d   = estado_q;
        end_d      = end_q;
        comp_d     = comp_q;
        erros_d    = erros_q;
        dur_d      = dur_q;
        held_d     = held_q;
        nota_lat_d = nota_lat_q;
        acerto_d   = 1'b0;
        erro_d     = 1'b0;
        we         = 1'b0;
        unique case (estado_q)
            OCIOSO, FIM: begin
                if (estado_q == FIM) estado_d = OCIOSO;
                if (inicia) begin
                    case (modo)
                        2'b01: begin
                            estado_d = GRAVA;
                            comp_d   = '0;
                            end_d    = '0;
                            held_d   = 1'b0;
                        end
                        2'b10, 2'b11: begin
                            end_d   = '0;
                            erros_d = '0;
                            dur_d   = '0;
                            if (comp_q == '0)       estado_d = FIM;
                            else if (modo == 2'b10) estado_d = TOCA;
                            else                    estado_d = PRATICA;
                        end
                        default: estado_d = OCIOSO;
                    endcase
                end
            end
            GRAVA: begin
                if (para) begin
                    estado_d = FIM;
                    held_d   = 1'b0;
                end else if (subida) begin
                    nota_lat_d = nota;
                    dur_d      = '0;
                    held_d     = 1'b1;
                end else if (descida && held_q) begin
                    we     = 1'b1;
                    held_d = 1'b0;
                    end_d  = end_q + AW'(1);
                    comp_d = comp_q + (AW+1)'(1);
                    if (end_q == AW'(DEPTH-1)) estado_d = FIM;
                end else if (tick && held_q) begin
                    dur_d = sat_dur(dur_q);
                end
            end
            TOCA: begin
                if (para) begin
                    estado_d = FIM;
                end else if (tick && rd_vld_q) begin
                    if (dur_prox == dur_ef) begin
                        dur_d = '0;
                        if (ultimo) begin
`ifdef GRAVADOR_LOOP_EN
                            end_d = '0;
`else
                            estado_d = FIM;
`endif
                        end else begin
                            end_d = end_q + AW'(1);
                        end
                    end else begin
                        dur_d = dur_prox[DUR_W-1:0];
                    end
                end
            end
            PRATICA: begin
                if (para) begin
                    estado_d = FIM;
                end else if (subida && rd_vld_q) begin
                    if (nota == rd_nota) begin
                        acerto_d = 1'b1;
                        if (ultimo) estado_d = FIM;
                        else        end_d = end_q + AW'(1);
                    end else begin
                        erro_d  = 1'b1;
                        erros_d = sat_erro(erros_q);
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
        // Read data trails the address by one cycle, so any address or mode change invalidates it.
        rd_vld_d = ((estado_d == TOCA) || (estado_d == PRATICA)) &&
                   (estado_d == estado_q) && (end_d == end_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            end_q    <= '0;
            comp_q   <= '0;
            erros_q  <= '0;
            dur_q    <= '0;
            held_q   <= 1'b0;
            nv_q     <= 1'b0;
            acerto_q <= 1'b0;
            erro_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            end_q    <= end_d;
            comp_q   <= comp_d;
            erros_q  <= erros_d;
            dur_q    <= dur_d;
            held_q   <= held_d;
            nv_q     <= nota_valida;
            acerto_q <= acerto_d;
            erro_q   <= erro_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Storage is left uninitialised; comprimento gates what is reachable.
    always_ff @(posedge clock) begin
        if (we) mem[end_q] <= {nota_lat_q, dur_q};
        rd_data_q  <= mem[end_q];
        nota_lat_q <= nota_lat_d;
    end

    assign nota_out        = rd_vld_q ? rd_nota : '0;
    assign nota_out_valida = rd_vld_q;
    assign endereco        = end_q;
    assign comprimento     = comp_q;
    assign erros           = erros_q;
    assign acerto          = acerto_q;
    assign erro            = erro_q;
    assign ocupado         = (estado_q == GRAVA) || (estado_q == TOCA) || (estado_q == PRATICA);
    assign fim             = (estado_q == FIM);
endmodule

// File: tb/tb_gravador_sequencia.sv
// Directed bench for gravador_sequencia (DEPTH=4): record, play, practice, abort, full, saturation, reset.
module tb_gravador_sequencia;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic [1:0]    modo = 2'b00;
    logic          inicia = 1'b0;
    logic          para = 1'b0;
    logic [3:0]    nota = 4'd0;
    logic          nota_valida = 1'b0;
    logic [3:0]    nota_out;
    logic          nota_out_valida;
    logic [AW-1:0] endereco;
    logic [AW:0]   comprimento;
    logic [2:0]    erros;
    logic          acerto, erro, ocupado, fim;

    int vec = 0;
    int errs = 0;

    gravador_sequencia #(.DEPTH(DEPTH), .NOTA_W(4), .DUR_W(4), .ERRO_W(3)) dut (
        .clock(clock), .reset(reset), .tick(tick), .modo(modo), .inicia(inicia),
        .para(para), .nota(nota), .nota_valida(nota_valida), .nota_out(nota_out),
        .nota_out_valida(nota_out_valida), .endereco(endereco), .comprimento(comprimento),
        .erros(erros), .acerto(acerto), .erro(erro), .ocupado(ocupado), .fim(fim)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start(input logic [1:0] m);
        modo = m; inicia = 1'b1; step(); inicia = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] n, input int ticks);
        nota = n; nota_valida = 1'b1; step();
        repeat (ticks) do_tick();
        nota_valida = 1'b0; step();
    endtask

    task automatic abort();
        para = 1'b1; step(); para = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(2); reset = 1'b0;
        vec++; if ({ocupado, fim, acerto, erro, nota_out_valida} !== 5'b0) begin
            $display("FAIL reset_flags: got %b want 00000", {ocupado, fim, acerto, erro, nota_out_valida}); errs++; end
        vec++; if (comprimento !== 3'd0 || endereco !== 2'd0 || erros !== 3'd0 || nota_out !== 4'd0) begin
            $display("FAIL reset_regs: comp %0d end %0d erros %0d nota %0d want all 0", comprimento, endereco, erros, nota_out); errs++; end
        start(2'b00);
        vec++; if (ocupado !== 1'b0 || fim !== 1'b0) begin
            $display("FAIL modo00_idle: ocupado %b fim %b want 0 0", ocupado, fim); errs++; end
    endtask

    task automatic test_record();
        start(2'b01);
        vec++; if (ocupado !== 1'b1) begin
            $display("FAIL rec_ocupado: got %b want 1", ocupado); errs++; end
        press(4'd5, 3);
        press(4'd9, 2);
        vec++; if (comprimento !== 3'd2 || endereco !== 2'd2) begin
            $display("FAIL rec_comp: comp %0d end %0d want 2 2", comprimento, endereco); errs++; end
        abort();
        vec++; if (fim !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL rec_para_fim: fim %b ocupado %b want 1 0", fim, ocupado); errs++; end
        step();
        vec++; if (fim !== 1'b0 || comprimento !== 3'd2) begin
            $display("FAIL rec_fim_exit: fim %b comp %0d want 0 2", fim, comprimento); errs++; end
    endtask

    task automatic test_play();
        start(2'b10);
        vec++; if (nota_out_valida !== 1'b0 || ocupado !== 1'b1) begin
            $display("FAIL play_first_cycle: valid %b ocupado %b want 0 1", nota_out_valida, ocupado); errs++; end
        step();
        for (int i = 0; i < 3; i++) begin
            vec++; if (nota_out !== 4'd5 || nota_out_valida !== 1'b1) begin
                $display("FAIL play_note0_t%0d: nota %0d valid %b want 5 1", i, nota_out, nota_out_valida); errs++; end
            do_tick();
        end
        vec++; if (endereco !== 2'd1 || nota_out_valida !== 1'b0) begin
            $display("FAIL play_advance: end %0d valid %b want 1 0", endereco, nota_out_valida); errs++; end
        step();
        for (int i = 0; i < 2; i++) begin
            vec++; if (nota_out !== 4'd9 || nota_out_valida !== 1'b1) begin
                $display("FAIL play_note1_t%0d: nota %0d valid %b want 9 1", i, nota_out, nota_out_valida); errs++; end
            do_tick();
        end
`ifdef GRAVADOR_LOOP_EN
        vec++; if (endereco !== 2'd0 || ocupado !== 1'b1) begin
            $display("FAIL play_wrap: end %0d ocupado %b want 0 1", endereco, ocupado); errs++; end
        step();
        vec++; if (nota_out !== 4'd5) begin
            $display("FAIL play_wrap_note: got %0d want 5", nota_out); errs++; end
        abort();
`endif
        vec++; if (fim !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL play_end: fim %b ocupado %b want 1 0", fim, ocupado); errs++; end
        step();
    endtask

    task automatic test_practice();
        start(2'b11); step();
        vec++; if (nota_out !== 4'd5 || erros !== 3'd0) begin
            $display("FAIL prat_expect: nota %0d erros %0d want 5 0", nota_out, erros); errs++; end
        nota = 4'd7; nota_valida = 1'b1; step();
        vec++; if (erro !== 1'b1 || acerto !== 1'b0 || erros !== 3'd1 || endereco !== 2'd0) begin
            $display("FAIL prat_wrong: erro %b acerto %b erros %0d end %0d want 1 0 1 0", erro, acerto, erros, endereco); errs++; end
        nota_valida = 1'b0; step();
        vec++; if (erro !== 1'b0) begin
            $display("FAIL prat_erro_pulse: got %b want 0", erro); errs++; end
        nota = 4'd5; nota_valida = 1'b1; step();
        vec++; if (acerto !== 1'b1 || endereco !== 2'd1) begin
            $display("FAIL prat_right0: acerto %b end %0d want 1 1", acerto, endereco); errs++; end
        nota_valida = 1'b0; step();
        nota = 4'd9; nota_valida = 1'b1; step();
        vec++; if (acerto !== 1'b1 || fim !== 1'b1 || erros !== 3'd1) begin
            $display("FAIL prat_right1: acerto %b fim %b erros %0d want 1 1 1", acerto, fim, erros); errs++; end
        nota_valida = 1'b0; step(2);
        vec++; if (erros !== 3'd1 || fim !== 1'b0 || acerto !== 1'b0) begin
            $display("FAIL prat_hold: erros %0d fim %b acerto %b want 1 0 0", erros, fim, acerto); errs++; end
    endtask

    task automatic test_abort();
        start(2'b01);
        press(4'd2, 1);
        nota = 4'd3; nota_valida = 1'b1; step();
        do_tick();
        abort();
        vec++; if (fim !== 1'b1 || comprimento !== 3'd1) begin
            $display("FAIL abort_held: fim %b comp %0d want 1 1", fim, comprimento); errs++; end
        nota_valida = 1'b0; step(2);
        vec++; if (comprimento !== 3'd1 || ocupado !== 1'b0) begin
            $display("FAIL abort_release: comp %0d ocupado %b want 1 0", comprimento, ocupado); errs++; end
    endtask

    task automatic test_full();
        start(2'b01);
        for (int i = 1; i <= 4; i++) press(4'(i), 1);
        vec++; if (fim !== 1'b1 || comprimento !== 3'd4) begin
            $display("FAIL full_fim: fim %b comp %0d want 1 4", fim, comprimento); errs++; end
        press(4'd5, 1);
        vec++; if (comprimento !== 3'd4 || ocupado !== 1'b0) begin
            $display("FAIL full_fifth: comp %0d ocupado %b want 4 0", comprimento, ocupado); errs++; end
    endtask

    task automatic test_saturation();
        start(2'b01);
        press(4'd6, 20);
        abort(); step();
        start(2'b10); step();
        vec++; if (nota_out !== 4'd6) begin
            $display("FAIL sat_note: got %0d want 6", nota_out); errs++; end
        repeat (14) do_tick();
        vec++; if (endereco !== 2'd0 || ocupado !== 1'b1 || nota_out !== 4'd6) begin
            $display("FAIL sat_dur_hold: end %0d ocupado %b nota %0d want 0 1 6", endereco, ocupado, nota_out); errs++; end
        do_tick();
`ifdef GRAVADOR_LOOP_EN
        abort();
`endif
        vec++; if (fim !== 1'b1) begin
            $display("FAIL sat_dur_end: fim %b want 1", fim); errs++; end
        step();
        start(2'b11); step();
        for (int i = 0; i < 9; i++) begin
            nota = 4'd0; nota_valida = 1'b1; step();
            nota_valida = 1'b0;
            if (i == 8) begin
                vec++; if (erro !== 1'b1 || erros !== 3'd7) begin
                    $display("FAIL sat_erros: erro %b erros %0d want 1 7", erro, erros); errs++; end
            end
            step();
        end
        abort();
        vec++; if (erros !== 3'd7 || fim !== 1'b1) begin
            $display("FAIL sat_erros_fim: erros %0d fim %b want 7 1", erros, fim); errs++; end
        step();
    endtask

    task automatic test_reset_mid_play();
        start(2'b10); step();
        vec++; if (ocupado !== 1'b1 || nota_out_valida !== 1'b1) begin
            $display("FAIL rst_pre: ocupado %b valid %b want 1 1", ocupado, nota_out_valida); errs++; end
        reset = 1'b1; step(); reset = 1'b0;
        vec++; if ({ocupado, fim, acerto, erro, nota_out_valida} !== 5'b0 || nota_out !== 4'd0 ||
                   endereco !== 2'd0 || comprimento !== 3'd0 || erros !== 3'd0) begin
            $display("FAIL rst_mid_toca: flags %b nota %0d end %0d comp %0d erros %0d want all 0",
                     {ocupado, fim, acerto, erro, nota_out_valida}, nota_out, endereco, comprimento, erros); errs++; end
        start(2'b10);
        vec++; if (fim !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL empty_play: fim %b ocupado %b want 1 0", fim, ocupado); errs++; end
        step();
    endtask

    initial begin
        test_reset();
        test_record();
        test_play();
        test_practice();
        test_abort();
        test_full();
        test_saturation();
        test_reset_mid_play();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
